// File: rtl/debounce_pulse_pkg.sv
// Shared types and constants for the push-button debounce stage.
// Imported by the synchronizer and the debounce FSM.
package debounce_pulse_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  localparam int CLOCK = 0;
  localparam int RESET = 1;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Counter only has to reach STABLE_CYCLES-1.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_pulse_sync_2ff.sv
// Two-flop synchronizer for the raw, asynchronous button level.
// Both flops clear to 0 on the asynchronous active-high reset.
module sync_2ff
  import debounce_pulse_pkg::*;
(
  input  logic [1:0] clock_reset,
  input  logic       d,
  output logic       q
);

  logic clock;
  logic reset;
  logic s1;
  logic s2;

  assign clock = clock_reset[CLOCK];
  assign reset = clock_reset[RESET];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a bouncy push-button and emits one registered
// single-cycle pulse per accepted press.
module debounce_pulse
  import debounce_pulse_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic [1:0] clock_reset,
  input  logic       i,
  output logic       o,
  output logic       level
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic clock;
  logic reset;
  logic s;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          o_q;
  logic          o_d;
  logic          level_q;
  logic          level_d;

  assign clock = clock_reset[CLOCK];
  assign reset = clock_reset[RESET];

  sync_2ff u_sync (
    .clock_reset (clock_reset),
    .d           (i),
    .q           (s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      level_q <= level_d;
    end
  end

  // o defaults low so a pulse never lasts past one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = 1'b0;
    level_d = level_q;
    case (state_q)
      LOW: begin
        if (s) begin
          state_d = RISE_WAIT;
          cnt_d   = ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          o_d     = 1'b1;
        end else begin
          cnt_d   = cnt_q + ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = FALL_WAIT;
          cnt_d   = ONE;
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign o     = o_q;
  assign level = level_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse with a 3-bit enable counter
// attached to o, as it is in the real datapath.
module tb_debounce_pulse;

  logic       clk;
  logic       rst;
  logic       i;
  logic       o;
  logic       level;
  logic [1:0] clock_reset;
  logic [2:0] ctr;

  int checks = 0;
  int errors = 0;

  assign clock_reset = {rst, clk};

  debounce_pulse #(.STABLE_CYCLES(4)) dut (
    .clock_reset (clock_reset),
    .i           (i),
    .o           (o),
    .level       (level)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Downstream 3-bit counter enabled by o.
  always @(posedge clk or posedge rst) begin
    if (rst) ctr <= 3'd0;
    else if (o) ctr <= ctr + 3'd1;
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i   = 1'b0;
    adv(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with the button already pressed.
    rst = 1'b1;
    i   = 1'b1;
    #10;
    chk("rst_o", {7'd0, o}, 8'd0);
    chk("rst_level", {7'd0, level}, 8'd0);
    adv(2);
    chk("rst_hold_o", {7'd0, o}, 8'd0);
    chk("rst_hold_level", {7'd0, level}, 8'd0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      adv(1);
      chk($sformatf("rel_o_E%0d", k), {7'd0, o}, {7'd0, k == 6});
      chk($sformatf("rel_lvl_E%0d", k), {7'd0, level}, {7'd0, k >= 6});
    end
    chk("rel_ctr", {5'd0, ctr}, 8'd1);

    // Short release while High is filtered.
    i = 1'b0;
    adv(2);
    i = 1'b1;
    for (int k = 3; k <= 12; k++) begin
      adv(1);
      chk($sformatf("lowglitch_lvl_%0d", k), {7'd0, level}, 8'd1);
      chk($sformatf("lowglitch_o_%0d", k), {7'd0, o}, 8'd0);
    end

    // Held release: level falls after E6, no pulse.
    i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      adv(1);
      chk($sformatf("fall_lvl_E%0d", k), {7'd0, level}, {7'd0, k < 6});
      chk($sformatf("fall_o_E%0d", k), {7'd0, o}, 8'd0);
    end
    chk("fall_ctr", {5'd0, ctr}, 8'd1);

    // Clean press held for 20 cycles.
    do_reset();
    i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      adv(1);
      chk($sformatf("press_o_E%0d", k), {7'd0, o}, {7'd0, k == 6});
      chk($sformatf("press_lvl_E%0d", k), {7'd0, level}, {7'd0, k >= 6});
    end
    chk("press_ctr", {5'd0, ctr}, 8'd1);

    // Three-cycle high glitch is rejected.
    do_reset();
    i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      adv(1);
      if (k == 3) i = 1'b0;
      chk($sformatf("glitch_o_E%0d", k), {7'd0, o}, 8'd0);
      chk($sformatf("glitch_lvl_E%0d", k), {7'd0, level}, 8'd0);
    end
    chk("glitch_ctr", {5'd0, ctr}, 8'd0);

    // Bounce 1,0,1,0 then held high.
    do_reset();
    i = 1'b1; adv(1);
    chk("bounce_o_a", {7'd0, o}, 8'd0);
    i = 1'b0; adv(1);
    chk("bounce_o_b", {7'd0, o}, 8'd0);
    i = 1'b1; adv(1);
    chk("bounce_o_c", {7'd0, o}, 8'd0);
    i = 1'b0; adv(1);
    chk("bounce_o_d", {7'd0, o}, 8'd0);
    i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      adv(1);
      chk($sformatf("bounce_o_E%0d", k), {7'd0, o}, {7'd0, k == 6});
      chk($sformatf("bounce_lvl_E%0d", k), {7'd0, level}, {7'd0, k >= 6});
    end
    chk("bounce_ctr", {5'd0, ctr}, 8'd1);

    // Asynchronous reset in the middle of RiseWait.
    do_reset();
    i = 1'b1;
    adv(4);
    rst = 1'b1;
    #1;
    chk("midrst_o", {7'd0, o}, 8'd0);
    chk("midrst_level", {7'd0, level}, 8'd0);
    adv(1);
    chk("midrst_hold_o", {7'd0, o}, 8'd0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      adv(1);
      chk($sformatf("midrst_o_E%0d", k), {7'd0, o}, {7'd0, k == 6});
      chk($sformatf("midrst_lvl_E%0d", k), {7'd0, level}, {7'd0, k >= 6});
    end
    chk("midrst_ctr", {5'd0, ctr}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Input-conditioning stage directly upstream of the 3-bit enable counter. Takes a raw, asynchronous, bouncy push-button level and synchronizes it. Filters glitches shorter than `STABLE_CYCLES`. Emits exactly one single-cycle pulse per debounced press on `o`, which drives the counter's 1-bit enable input `i`, so the count advances once per physical press.

## Interface

Parameters:
- `STABLE_CYCLES`, default 4. Consecutive synchronized samples required to accept a level change. Legal range 2..255.

Ports:
- `clock_reset`, input, 2 bits. Bit 0 = `clock`; all flops update on its rising edge. Bit 1 = `reset`, which is asynchronous and active-high.
- `i`, input, 1 bit. Raw button level. It is asynchronous to `clock` and may bounce.
- `o`, output, 1 bit. One-cycle pulse on each accepted rising edge of the debounced level. Registered.
- `level`, output, 1 bit. Debounced, synchronized button level. Registered.

## Operation

- Synchronizer:
  - Two flops, `s1 <= i` and `s2 <= s1`.
  - FSM and counter use only `s2` (called `s` below).
- State machine, 2-bit state, one counter `cnt` of width ceil(log2(`STABLE_CYCLES`)):
  - `Low`:
    - `s=1` → `RiseWait`, `cnt<=1`.
    - Otherwise stay; `cnt<=0`.
  - `RiseWait`:
    - `s=0` → `Low`, `cnt<=0` (glitch rejected).
    - `s=1` and `cnt==STABLE_CYCLES-1` → `High`, `cnt<=0`, `level<=1`, `o<=1`.
    - Otherwise `cnt<=cnt+1`.
  - `High`:
    - `s=0` → `FallWait`, `cnt<=1`.
    - Otherwise stay.
  - `FallWait`:
    - `s=1` → `High`, `cnt<=0`.
    - `s=0` and `cnt==STABLE_CYCLES-1` → `Low`, `cnt<=0`, `level<=0`. No pulse on release.
    - Otherwise `cnt<=cnt+1`.
- `o` is high for exactly one cycle per `Low`→`High` acceptance. It deasserts on the next edge unconditionally.
- `cnt` never wraps. It is compared against `STABLE_CYCLES-1` and cleared on every state exit.
- Unused state encodings go to `Low` with `cnt<=0`, `o<=0`, `level<=0`.

## Timing

- Reset values while `clock_reset[1]=1`, all immediately and without a clock edge:
  - `s1=0`, `s2=0`, state `Low`, `cnt=0`.
  - `o=0`, `level=0`.
- Rise latency:
  - Condition: `i` rises before clock edge E1 and is held.
  - `s` is first sampled high by the FSM at E3.
  - `level` and `o` rise after edge E(2+`STABLE_CYCLES`); this is E6 for the default.
  - `o` falls after the following edge.
- Fall latency: `level` falls after E(2+`STABLE_CYCLES`), counted from the falling `i`.
- Glitch rules:
  - A high excursion shorter than `STABLE_CYCLES` synchronized samples produces neither a pulse nor a `level` change.
  - A low excursion of the same length during `High` does not drop `level`.
- Reset mid-operation:
  - Any pending pulse or count is discarded.
  - If `i` is still high when reset releases, it is treated as a fresh press: the pulse occurs 2+`STABLE_CYCLES` edges after the first edge following release.
- Downstream compatibility:
  - `o` is 0 throughout reset.
  - `o` changes only just after rising edges, giving the downstream counter's combinational kernel a full cycle of setup.

## Structure

Shared package contents:
- State enumeration: `Low=0`, `RiseWait=1`, `High=2`, `FallWait=3`.
- `clock_reset` bit-index constants: `CLOCK=0`, `RESET=1`.
- Default `STABLE_CYCLES`.

Sub-module:
- `sync_2ff`: two-flop synchronizer with asynchronous active-high reset to 0, taking the same `clock_reset` bus.
- FSM, counter and output registers stay in `debounce_pulse`.

## Test plan

All scenarios use `STABLE_CYCLES=4` and a clock period of 100.

- Reset: hold `clock_reset=2'b10` with `i=1` → `o=0` and `level=0` immediately. After release, `o` pulses once 6 edges later.
- Clean press: `i` goes 0→1 before E1 and is held for 20 cycles → `o=1` only in the cycle after E6; `level=1` from E6 onward. The attached counter goes 000→001 and stays there.
- Glitch reject: `i=1` for 3 cycles, then 0 → `o` and `level` stay 0 throughout; the counter stays at 000.
- Bounce: `i` sequence 1,0,1,0,1 per cycle, then held at 1 → exactly one pulse, 6 edges after the final 0→1.
- Release filtering: from `High`, drive `i=0` for 2 cycles then 1 → `level` stays 1 with no pulse. Then `i=0` held → `level` falls after edge 6, still with no pulse.
- Asynchronous reset mid-`RiseWait`: assert reset between E4 and E5 with `i` held high → `o=0` and `level=0` before E5. After release, one pulse 6 edges later; the counter shows 001, not 002.
